// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: skewed operand feed, overflow capture, row readout.
// Optional busy-cycle performance counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int DIM   = 4,
  parameter int CNT_W = 6,
  parameter int ROW_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 pe_start_o,
  output logic [CNT_W-1:0]     step_o,
  output logic [DIM-1:0]       feed_en_o,
  input  logic [DIM*DIM-1:0]   ovf_i,
  output logic                 ovf_o,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]          perf_cycles_o,
`endif
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ROW_W-1:0]     res_row_o,
  output logic                 done_o
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(3*DIM-3);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(DIM-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_READ    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic             busy_d, pe_start_d, ovf_d, valid_d, done_d;
  logic [CNT_W-1:0] step_out_d;
  logic [DIM-1:0]   feed_en_d;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic; step saturates at its terminal value, row returns to 0 on leaving READ
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COMPUTE;
          step_d  = '0;
          row_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (step_q == STEP_LAST) begin
          state_d = S_READ;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      S_READ: begin
        if (res_ready_i) begin
          if (row_q == ROW_LAST) begin
            state_d = S_IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          row_d = row_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        row_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    pe_start_d = (state_d != S_IDLE);
    valid_d    = (state_d == S_READ);
    done_d     = (state_q == S_READ) && (state_d == S_IDLE);
    step_out_d = (state_d == S_COMPUTE) ? step_d : '0;
    feed_en_d  = '0;
    for (int i = 0; i < DIM; i++) begin
      if ((state_d == S_COMPUTE) && (step_d >= CNT_W'(i)) && (step_d <= CNT_W'(i + DIM - 1))) begin
        feed_en_d[i] = 1'b1;
      end else begin
        feed_en_d[i] = 1'b0;
      end
    end
    // Overflow is sampled on the same edge as the final PE update
    if ((state_q == S_IDLE) && start_i) begin
      ovf_d = 1'b0;
    end else if ((state_q == S_COMPUTE) && (step_q == STEP_LAST)) begin
      ovf_d = |ovf_i;
    end else begin
      ovf_d = ovf_o;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o      <= 1'b0;
      pe_start_o  <= 1'b0;
      step_o      <= '0;
      feed_en_o   <= '0;
      ovf_o       <= 1'b0;
      res_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      busy_o      <= busy_d;
      pe_start_o  <= pe_start_d;
      step_o      <= step_out_d;
      feed_en_o   <= feed_en_d;
      ovf_o       <= ovf_d;
      res_valid_o <= valid_d;
      done_o      <= done_d;
    end
  end

  assign res_row_o = row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] op_cnt_q, op_cnt_d;
  logic [31:0] perf_q, perf_d;

  // Busy-cycle count: starts at 1 in the first COMPUTE cycle, published on the READ->IDLE edge
  always_comb begin
    op_cnt_d = op_cnt_q;
    perf_d   = perf_q;
    if ((state_q == S_IDLE) && start_i) begin
      op_cnt_d = 32'd1;
    end else if ((state_q != S_IDLE) && (op_cnt_q != 32'hFFFF_FFFF)) begin
      op_cnt_d = op_cnt_q + 32'd1;
    end else begin
      op_cnt_d = op_cnt_q;
    end
    if (done_d) begin
      perf_d = op_cnt_q;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_q <= 32'd0;
      perf_q   <= 32'd0;
    end else begin
      op_cnt_q <= op_cnt_d;
      perf_q   <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl with DIM=4.
module tb_systolic_ctrl;
  localparam int DIM   = 4;
  localparam int CNT_W = 6;
  localparam int ROW_W = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 start_i;
  logic                 busy_o;
  logic                 pe_start_o;
  logic [CNT_W-1:0]     step_o;
  logic [DIM-1:0]       feed_en_o;
  logic [DIM*DIM-1:0]   ovf_i;
  logic                 ovf_o;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [ROW_W-1:0]     res_row_o;
  logic                 done_o;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]          perf_cycles_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] feed_tab [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

  always #5 clk_i = ~clk_i;

  systolic_ctrl #(.DIM(DIM), .CNT_W(CNT_W), .ROW_W(ROW_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .pe_start_o  (pe_start_o),
    .step_o      (step_o),
    .feed_en_o   (feed_en_o),
    .ovf_i       (ovf_i),
    .ovf_o       (ovf_o),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .perf_cycles_o (perf_cycles_o),
`endif
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_row_o   (res_row_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic start_op();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Walk the 10 compute steps; optional ovf pulse and stray start at given steps
  task automatic compute_phase(input int ovf_t, input int start_t, input string tag);
    for (int t = 0; t < 10; t++) begin
      check($sformatf("%s_step%0d", tag, t), 32'(step_o), 32'(t));
      check($sformatf("%s_feed%0d", tag, t), 32'(feed_en_o), 32'(feed_tab[t]));
      check($sformatf("%s_busy%0d", tag, t), 32'(busy_o), 32'd1);
      check($sformatf("%s_pes%0d", tag, t), 32'(pe_start_o), 32'd1);
      check($sformatf("%s_nval%0d", tag, t), 32'(res_valid_o), 32'd0);
      ovf_i   = (t == ovf_t) ? 16'h0020 : 16'h0000;
      start_i = (t == start_t);
      tick();
    end
    ovf_i   = 16'h0000;
    start_i = 1'b0;
  endtask

  // Read the four rows, optionally stalling on one row; ends in the done cycle
  task automatic read_phase(input int stall_row, input int stall_n, input logic exp_ovf, input string tag);
    for (int r = 0; r < DIM; r++) begin
      if (r == stall_row) begin
        res_ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check($sformatf("%s_srow%0d", tag, s), 32'(res_row_o), 32'(r));
          check($sformatf("%s_sval%0d", tag, s), 32'(res_valid_o), 32'd1);
          check($sformatf("%s_spes%0d", tag, s), 32'(pe_start_o), 32'd1);
          check($sformatf("%s_sdone%0d", tag, s), 32'(done_o), 32'd0);
          tick();
        end
        res_ready_i = 1'b1;
      end
      check($sformatf("%s_row%0d", tag, r), 32'(res_row_o), 32'(r));
      check($sformatf("%s_val%0d", tag, r), 32'(res_valid_o), 32'd1);
      check($sformatf("%s_rfeed%0d", tag, r), 32'(feed_en_o), 32'd0);
      check($sformatf("%s_rstep%0d", tag, r), 32'(step_o), 32'd0);
      check($sformatf("%s_ovf%0d", tag, r), 32'(ovf_o), 32'(exp_ovf));
      check($sformatf("%s_ndone%0d", tag, r), 32'(done_o), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_idle_pes"}, 32'(pe_start_o), 32'd0);
    check({tag, "_idle_val"}, 32'(res_valid_o), 32'd0);
    check({tag, "_idle_row"}, 32'(res_row_o), 32'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b1;
    ovf_i       = 16'h0000;
    res_ready_i = 1'b1;

    // 1. Reset held with start asserted
    repeat (3) tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_pes", 32'(pe_start_o), 32'd0);
    check("rst_step", 32'(step_o), 32'd0);
    check("rst_feed", 32'(feed_en_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_val", 32'(res_valid_o), 32'd0);
    check("rst_row", 32'(res_row_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("rst_perf", perf_cycles_o, 32'd0);
`endif
    start_i = 1'b0;
    rst_ni  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_busy%0d", i), 32'(busy_o), 32'd0);
    end

    // 2. Single op, ready tied high: 10 compute + 4 read cycles
    start_op();
    compute_phase(-1, -1, "op");
    read_phase(-1, 0, 1'b0, "op");
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf_single", perf_cycles_o, 32'd14);
`endif
    tick();
    check("op_done_pulse", 32'(done_o), 32'd0);

    // 3. Backpressure on row 2 for 5 cycles
    start_op();
    compute_phase(-1, -1, "bp");
    read_phase(2, 5, 1'b0, "bp");
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf_bp", perf_cycles_o, 32'd19);
`endif
    tick();

    // 4. Overflow sampled at t=9, held after done, cleared on next start
    start_op();
    compute_phase(9, -1, "ov");
    read_phase(-1, 0, 1'b1, "ov");
    tick();
    check("ov_hold_idle", 32'(ovf_o), 32'd1);
    start_op();
    check("ov_clr_start", 32'(ovf_o), 32'd0);
    compute_phase(3, -1, "ov3");
    read_phase(-1, 0, 1'b0, "ov3");

    // 5. Start during COMPUTE is ignored; start with done begins next op
    tick();
    start_op();
    compute_phase(-1, 4, "col");
    read_phase(-1, 0, 1'b0, "col");
    start_op();
    check("col_restart_busy", 32'(busy_o), 32'd1);
    check("col_restart_pes", 32'(pe_start_o), 32'd1);
    check("col_restart_step", 32'(step_o), 32'd0);
    check("col_restart_done", 32'(done_o), 32'd0);
    compute_phase(-1, -1, "col2");
    read_phase(-1, 0, 1'b0, "col2");
    tick();

    // 6. Reset at t=5 forces IDLE with no done pulse
    start_op();
    repeat (5) tick();
    check("mid_step5", 32'(step_o), 32'd5);
    rst_ni = 1'b0;
    #1;
    check("mid_busy", 32'(busy_o), 32'd0);
    check("mid_pes", 32'(pe_start_o), 32'd0);
    check("mid_step", 32'(step_o), 32'd0);
    check("mid_feed", 32'(feed_en_o), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("mid_perf", perf_cycles_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_nodone%0d", i), 32'(done_o), 32'd0);
      check($sformatf("mid_idle%0d", i), 32'(busy_o), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
